// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: icodes, instruction sizing
// and the fetch-side state encoding.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam int INST_MAX_BYTES = 10;

   typedef enum logic [1:0] {
      FS_FILL,
      FS_WAIT,
      FS_DROP,
      FS_FAULT
   } fetch_state_t;

   // Encoded size in bytes; unknown icodes are treated as 1 byte.
   function automatic logic [3:0] inst_len(input logic [3:0] icode);
      logic [3:0] len;
      case (icode)
         IHALT, INOP, IRET:               len = 4'd1;
         IRRMOVQ, IOPQ, IPUSHQ, IPOPQ:    len = 4'd2;
         IJXX, ICALL:                     len = 4'd9;
         IIRMOVQ, IRMMOVQ, IMRMOVQ:       len = 4'd10;
         default:                         len = 4'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/inst_len_dec.sv
// Y86 instruction length decoder from the icode nibble.
// Shared between the fetch buffer and decode.
module inst_len_dec
   import y86_pkg::*;
(
   input  logic [3:0] icode,
   output logic [3:0] len,
   output logic       ill
);

   assign len = inst_len(icode);
   assign ill = icode > IPOPQ;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: circular byte queue fed by
// fixed-size memory fetches, presenting the head instruction.
module fetch_buffer
   import y86_pkg::*;
#(
   parameter int          FETCH_BYTES = 8,
   parameter int          DEPTH       = 32,
   parameter logic [63:0] RESET_PC    = 64'h0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     redirect,
   input  logic [63:0]              redirect_pc,
   output logic                     mem_req,
   output logic [63:0]              mem_addr,
   input  logic                     mem_rvalid,
   input  logic [8*FETCH_BYTES-1:0] mem_rdata,
   input  logic                     mem_err,
   output logic                     win_valid,
   output logic [79:0]              win_bytes,
   output logic [3:0]               win_len,
   output logic [63:0]              win_pc,
   output logic                     win_err,
   output logic                     win_ill,
   input  logic                     take
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = AW + 1;
   localparam logic [OW-1:0] FB  = OW'(FETCH_BYTES);
   localparam logic [OW-1:0] CAP = OW'(DEPTH);

   logic [7:0]    q [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [OW-1:0] occ;
   logic [OW-1:0] free;
   logic [OW-1:0] len_o;
   logic [63:0]   fetch_pc;
   fetch_state_t  state;
   fetch_state_t  state_nx;
   logic          issue;
   logic          wr;
   logic          tk;

   assign free  = CAP - occ;
   assign len_o = OW'(win_len);

   inst_len_dec u_len (
      .icode (win_bytes[7:4]),
      .len   (win_len),
      .ill   (win_ill)
   );

   // A fault only blocks the head if that head is incomplete.
   assign win_err   = (state == FS_FAULT) && (occ < len_o);
   assign win_valid = (occ >= len_o) || win_err;
   assign tk        = take && win_valid && !win_err && !redirect;

   // Fetch FSM next state; redirect wins over everything.
   always_comb begin
      state_nx = state;
      issue    = 1'b0;
      wr       = 1'b0;
      unique case (state)
         FS_FILL: begin
            if (free >= FB) begin
               issue    = 1'b1;
               state_nx = FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (mem_rvalid) begin
               if (mem_err) begin
                  state_nx = FS_FAULT;
               end else begin
                  wr       = 1'b1;
                  state_nx = FS_FILL;
               end
            end
         end
         FS_DROP: begin
            if (mem_rvalid) state_nx = FS_FILL;
         end
         FS_FAULT: state_nx = FS_FAULT;
         default:  state_nx = FS_FILL;
      endcase
      if (redirect) begin
         issue = 1'b0;
         wr    = 1'b0;
         if ((state == FS_WAIT || state == FS_DROP) && !mem_rvalid)
            state_nx = FS_DROP;
         else
            state_nx = FS_FILL;
      end
   end

   // Fetch FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FS_FILL;
      else        state <= state_nx;
   end

   // Pointers, occupancy, PCs and the registered request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head     <= '0;
         tail     <= '0;
         occ      <= '0;
         win_pc   <= RESET_PC;
         fetch_pc <= RESET_PC;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else begin
         mem_req <= issue;
         if (issue) mem_addr <= fetch_pc;
         if (redirect) begin
            head     <= tail;
            occ      <= '0;
            win_pc   <= redirect_pc;
            fetch_pc <= redirect_pc;
         end else begin
            if (wr) begin
               tail     <= tail + AW'(FETCH_BYTES);
               fetch_pc <= fetch_pc + 64'(FETCH_BYTES);
            end
            if (tk) begin
               head   <= head + AW'(win_len);
               win_pc <= win_pc + 64'(win_len);
            end
            occ <= occ + (wr ? FB : '0) - (tk ? len_o : '0);
         end
      end
   end

   // Byte storage; stale slots are masked by occupancy on read.
   always_ff @(posedge clk) begin
      if (wr) begin
         for (int i = 0; i < FETCH_BYTES; i++)
            q[tail + AW'(i)] <= mem_rdata[8*i +: 8];
      end
   end

   // Head window: bytes past the occupancy read as zero.
   always_comb begin
      win_bytes = '0;
      for (int i = 0; i < INST_MAX_BYTES; i++) begin
         if (OW'(i) < occ)
            win_bytes[8*i +: 8] = q[head + AW'(i)];
      end
   end

endmodule

// File: tb/tb_fetch_buffer.sv
// Scoreboard bench for fetch_buffer: directed programs,
// a latency-controlled memory model and a window monitor.
module tb_fetch_buffer;

   typedef struct {
      logic [63:0] pc;
      logic [3:0]  len;
      logic        ill;
      logic        err;
      logic [79:0] bytes;
      int          nb;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect = 1'b0;
   logic [63:0] redirect_pc = '0;
   logic        mem_req;
   logic [63:0] mem_addr;
   logic        mem_rvalid = 1'b0;
   logic [63:0] mem_rdata = '0;
   logic        mem_err = 1'b0;
   logic        win_valid;
   logic [79:0] win_bytes;
   logic [3:0]  win_len;
   logic [63:0] win_pc;
   logic        win_err;
   logic        win_ill;
   logic        take = 1'b0;

   int          errors = 0;
   int          checks = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [7:0]  img [512];
   int          lat = 1;
   logic        err_en = 1'b0;
   logic [63:0] err_addr = '0;
   int          resp_cnt = 0;
   bit          busy = 1'b0;
   int          pops = 0;
   int          pop_base = 0;
   bit          chk_full = 1'b0;
   bit          req_seen = 1'b0;

   fetch_buffer #(
      .FETCH_BYTES (8),
      .DEPTH       (32),
      .RESET_PC    (64'h0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .mem_err     (mem_err),
      .win_valid   (win_valid),
      .win_bytes   (win_bytes),
      .win_len     (win_len),
      .win_pc      (win_pc),
      .win_err     (win_err),
      .win_ill     (win_ill),
      .take        (take)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [79:0] got,
                        input logic [79:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   function automatic logic [79:0] bmask(input int nb);
      logic [79:0] m;
      m = '0;
      for (int b = 0; b < 10; b++)
         if (b < nb) m[8*b +: 8] = 8'hFF;
      return m;
   endfunction

   task automatic push(input logic [63:0] pc, input logic [3:0] len,
                       input logic ill, input logic err,
                       input logic [79:0] b, input int nb);
      exp_t e;
      e.pc = pc; e.len = len; e.ill = ill;
      e.err = err; e.bytes = b; e.nb = nb;
      sb.push_back(e);
   endtask

   // Memory model: one response, lat cycles after the request.
   initial begin : responder
      logic [63:0] a;
      forever begin
         @(negedge clk);
         if (rst_n && mem_req) begin
            a = mem_addr;
            busy = 1'b1;
            repeat (lat) @(negedge clk);
            for (int i = 0; i < 8; i++)
               mem_rdata[8*i +: 8] = img[a[8:0] + 9'(i)];
            mem_err = err_en && (a == err_addr);
            mem_rvalid = 1'b1;
            resp_cnt++;
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_err = 1'b0;
            busy = 1'b0;
         end
      end
   end

   // Monitor: every accepted window is checked against the scoreboard.
   always @(negedge clk) begin
      if (rst_n) begin
         if (chk_full && mem_req && !req_seen) begin
            req_seen = 1'b1;
            check("refill_after_takes", 80'(pops - pop_base), 80'd9);
         end
         if (win_valid && take) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_window: got pc %0h want none",
                        win_pc);
            end else begin
               mon_e = sb.pop_front();
               check($sformatf("win_meta@%0h", mon_e.pc),
                     80'({win_pc, win_len, win_ill, win_err}),
                     80'({mon_e.pc, mon_e.len, mon_e.ill, mon_e.err}));
               check($sformatf("win_bytes@%0h", mon_e.pc),
                     win_bytes & bmask(mon_e.nb),
                     mon_e.bytes & bmask(mon_e.nb));
            end
            pops++;
         end
      end
   end

   task automatic run_takes(input string nm);
      int n;
      n = 0;
      take = 1'b1;
      while (sb.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      take = 1'b0;
      check({nm, "_drained"}, 80'(sb.size()), 80'd0);
      sb.delete();
   endtask

   task automatic do_redirect(input logic [63:0] pc);
      redirect = 1'b1;
      redirect_pc = pc;
      @(posedge clk); #1;
      redirect = 1'b0;
   endtask

   task automatic quiesce();
      int n;
      repeat (40) @(posedge clk);
      n = 0;
      while ((busy || mem_req) && n < 50) begin
         @(posedge clk);
         n++;
      end
      #1;
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int  n;
      bit  seen;
      int  base;
      for (int i = 0; i < 512; i++) img[i] = 8'h00;
      img[0] = 8'h10;
      img[1] = 8'h20; img[2] = 8'h12;
      img[3] = 8'h30; img[4] = 8'hF3;
      for (int i = 0; i < 8; i++) img[5+i] = 8'(i + 1);
      for (int i = 64; i < 192; i++) img[i] = 8'h10;
      img[256] = 8'h60; img[257] = 8'h01;
      for (int i = 258; i < 320; i++) img[i] = 8'h10;
      for (int i = 384; i < 388; i++) img[i] = 8'h10;
      img[388] = 8'h80; img[389] = 8'hAA;
      img[390] = 8'hBB; img[391] = 8'hCC;
      img[448] = 8'hF0;
      for (int i = 449; i < 480; i++) img[i] = 8'h10;

      // Reset values
      repeat (3) @(posedge clk); #1;
      check("rst_mem_req", 80'(mem_req), 80'd0);
      check("rst_mem_addr", 80'(mem_addr), 80'd0);
      check("rst_win_valid", 80'(win_valid), 80'd0);
      check("rst_win_bytes", win_bytes, 80'd0);
      check("rst_win_len", 80'(win_len), 80'd1);
      check("rst_win_pc", 80'(win_pc), 80'd0);
      check("rst_err_ill", 80'({win_err, win_ill}), 80'd0);

      // T1: short program from address 0
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_req", 80'({mem_req, mem_addr}), {15'd0, 1'b1, 64'h0});
      push(64'd0, 4'd1, 1'b0, 1'b0, 80'h10, 1);
      push(64'd1, 4'd2, 1'b0, 1'b0, 80'h1220, 2);
      push(64'd3, 4'd10, 1'b0, 1'b0, 80'h0807060504030201F330, 10);
      push(64'd13, 4'd1, 1'b0, 1'b0, 80'h00, 1);
      run_takes("t1");

      // T2: irmovq at pc 6 needs two responses
      quiesce();
      img[6] = 8'h30; img[7] = 8'hF4;
      for (int i = 0; i < 8; i++) img[8+i] = 8'h11 + 8'(i);
      base = resp_cnt;
      do_redirect(64'd6);
      seen = 1'b0;
      for (n = 0; n < 40 && !seen; n++) begin
         @(negedge clk);
         if (win_valid) seen = 1'b1;
      end
      check("t2_resp_before_valid",
            80'({seen, 32'(resp_cnt - base)}), {47'd0, 1'b1, 32'd2});
      @(posedge clk); #1;
      push(64'd6, 4'd10, 1'b0, 1'b0, 80'h1817161514131211F430, 10);
      run_takes("t2");

      // T3: full queue blocks fetch until enough bytes leave
      quiesce();
      do_redirect(64'h40);
      repeat (30) @(posedge clk);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      check("t3_no_req_full", 80'(seen), 80'd0);
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++)
         push(64'h40 + 64'(i), 4'd1, 1'b0, 1'b0, 80'h10, 1);
      pop_base = pops;
      req_seen = 1'b0;
      chk_full = 1'b1;
      run_takes("t3");
      chk_full = 1'b0;
      check("t3_req_seen", 80'(req_seen), 80'd1);

      // T4: async reset, then redirect with a request in flight
      quiesce();
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1;
      check("async_rst", 80'({win_valid, mem_req, win_len, win_pc}),
            {10'd0, 1'b0, 1'b0, 4'd1, 64'd0});
      lat = 4;
      @(negedge clk); rst_n = 1'b1;
      seen = 1'b0;
      for (n = 0; n < 100 && !seen; n++) begin
         @(negedge clk);
         if (mem_req && mem_addr == 64'h18) seen = 1'b1;
      end
      check("t4_req_18", 80'(seen), 80'd1);
      @(posedge clk); #1;
      base = resp_cnt;
      do_redirect(64'h100);
      seen = 1'b0;
      for (n = 0; n < 60 && !seen; n++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      check("t4_next_req", 80'({seen, mem_addr}), {15'd0, 1'b1, 64'h100});
      check("t4_after_drop", 80'(resp_cnt - base >= 1), 80'd1);
      @(posedge clk); #1;
      push(64'h100, 4'd2, 1'b0, 1'b0, 80'h0160, 2);
      push(64'h102, 4'd1, 1'b0, 1'b0, 80'h10, 1);
      push(64'h103, 4'd1, 1'b0, 1'b0, 80'h10, 1);
      run_takes("t4");

      // T5: fault on the second fetch under a partial call
      lat = 1;
      quiesce();
      err_en = 1'b1;
      err_addr = 64'h188;
      do_redirect(64'h180);
      for (int i = 0; i < 4; i++)
         push(64'h180 + 64'(i), 4'd1, 1'b0, 1'b0, 80'h10, 1);
      for (int i = 0; i < 4; i++)
         push(64'h184, 4'd9, 1'b0, 1'b1, 80'hCCBBAA80, 10);
      run_takes("t5");
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (mem_req) seen = 1'b1;
      end
      check("t5_no_req_fault", 80'(seen), 80'd0);
      @(posedge clk); #1;
      err_en = 1'b0;

      // T6: redirect clears the fault; illegal icode
      do_redirect(64'h1C0);
      check("t6_redirect_clr", 80'({win_valid, win_err}), 80'd0);
      push(64'h1C0, 4'd1, 1'b1, 1'b0, 80'hF0, 1);
      push(64'h1C1, 4'd1, 1'b0, 1'b0, 80'h10, 1);
      run_takes("t6");

      repeat (5) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
